// File: rtl/mnk_game_engine.sv
// m,n,k game engine: N x N board, K-in-a-row win, sequential scan from the last stone.
// Optional move history with one-cycle undo when MNK_UNDO_EN is defined.
module mnk_game_engine #(
  parameter int N       = 3,
  parameter int K       = 3,
  parameter int COORD_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [COORD_W-1:0]          x_in,
  input  logic [COORD_W-1:0]          y_in,
  input  logic                        make_move,
  input  logic                        undo,
  output logic                        move_ready,
  output logic                        move_err,
  output logic                        move_done,
  output logic                        cur_player,
  output logic [1:0]                  winner,
  output logic                        tie,
  output logic [$clog2(N*N+1)-1:0]    move_count,
  output logic [2*N*N-1:0]            board
);

  localparam int NN    = N * N;
  localparam int CNT_W = $clog2(NN + 1);
  localparam int RUN_W = $clog2(K + 1);
  localparam int IW    = $clog2(2 * NN);
  localparam int HW    = (NN > 1) ? $clog2(NN) : 1;

  localparam logic [COORD_W-1:0]        N_U    = COORD_W'(N);
  localparam logic signed [COORD_W:0]   N_S    = (COORD_W + 1)'(N);
  localparam logic signed [COORD_W:0]   S_ZERO = '0;
  localparam logic signed [COORD_W:0]   S_ONE  = {{COORD_W{1'b0}}, 1'b1};
  localparam logic signed [COORD_W:0]   S_MONE = '1;
  localparam logic [RUN_W-1:0]          K_R    = RUN_W'(K);
  localparam logic [CNT_W-1:0]          NN_C   = CNT_W'(NN);

  typedef enum logic [2:0] {IDLE, SCAN_POS, SCAN_NEG, NEXT_DIR, OVER} state_t;

  state_t state_q, state_d;

  logic signed [COORD_W:0] pr_q, pc_q, cr_q, cc_q;
  logic [1:0]              dir_q;
  logic [RUN_W-1:0]        run_q;

  // Bit offset of cell (r,c) in the packed board; row 0 / column 0 sits in the top bits.
  function automatic logic [IW-1:0] cell_idx(input int r, input int c);
    return IW'(2 * (NN - 1 - (r * N + c)));
  endfunction

  logic [1:0]              pcode;
  logic signed [COORD_W:0] br, bc, dr, dc, nr, nc;
  logic                    in_bnd, step_hit, win_hit, coord_ok;
  logic [IW-1:0]           nidx, tidx;
  logic [1:0]              ncell, tcell;
  logic                    accept, reject, undo_act, undo_go, undo_bad;

  assign pcode      = cur_player ? 2'b10 : 2'b01;
  assign move_ready = (state_q == IDLE);

  always_comb begin
    br = S_ZERO;
    bc = S_ONE;
    case (dir_q)
      2'd0: begin br = S_ZERO; bc = S_ONE;  end
      2'd1: begin br = S_ONE;  bc = S_ZERO; end
      2'd2: begin br = S_ONE;  bc = S_ONE;  end
      default: begin br = S_ONE; bc = S_MONE; end
    endcase
    dr = (state_q == SCAN_NEG) ? (S_ZERO - br) : br;
    dc = (state_q == SCAN_NEG) ? (S_ZERO - bc) : bc;
    nr = cr_q + dr;
    nc = cc_q + dc;
    in_bnd = (nr >= S_ZERO) && (nr < N_S) && (nc >= S_ZERO) && (nc < N_S);
    nidx  = '0;
    ncell = 2'b00;
    if (in_bnd) begin
      nidx  = cell_idx(int'(nr), int'(nc));
      ncell = board[nidx +: 2];
    end
    step_hit = in_bnd && (ncell == pcode) && (run_q < K_R);
    win_hit  = step_hit && ((run_q + RUN_W'(1)) == K_R);
  end

  always_comb begin
    coord_ok = (x_in < N_U) && (y_in < N_U);
    tidx  = '0;
    tcell = 2'b00;
    if (coord_ok) begin
      tidx  = cell_idx(int'(x_in), int'(y_in));
      tcell = board[tidx +: 2];
    end
  end

`ifdef MNK_UNDO_EN
  logic [2*COORD_W-1:0] hist_q [NN];
  logic [2*COORD_W-1:0] pop_ent;
  logic [IW-1:0]        pidx;
  logic [1:0]           pop_code;

  assign undo_act = undo && ((state_q == IDLE) || (state_q == OVER));
  assign undo_go  = undo_act && (move_count != '0);
  assign undo_bad = undo_act && (move_count == '0);
  assign pop_ent  = hist_q[HW'(move_count - CNT_W'(1))];
  assign pidx     = cell_idx(int'(pop_ent[2*COORD_W-1:COORD_W]), int'(pop_ent[COORD_W-1:0]));
  assign pop_code = board[pidx +: 2];

  always_ff @(posedge clk) begin
    if (accept) hist_q[HW'(move_count)] <= {x_in, y_in};
  end
`else
  logic unused_undo;
  assign unused_undo = undo;
  assign undo_act    = 1'b0;
  assign undo_go     = 1'b0;
  assign undo_bad    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!undo_act && make_move) begin
          if (coord_ok && (tcell == 2'b00)) begin
            accept  = 1'b1;
            state_d = SCAN_POS;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SCAN_POS: begin
        if (win_hit)       state_d = OVER;
        else if (!step_hit) state_d = SCAN_NEG;
      end
      SCAN_NEG: begin
        if (win_hit)       state_d = OVER;
        else if (!step_hit) state_d = NEXT_DIR;
      end
      NEXT_DIR: begin
        if (dir_q != 2'd3)           state_d = SCAN_POS;
        else if (move_count == NN_C) state_d = OVER;
        else                         state_d = IDLE;
      end
      OVER: begin
        if (undo_go)                        state_d = IDLE;
        else if (!undo_act && make_move)    reject  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board      <= '0;
      winner     <= 2'b00;
      tie        <= 1'b0;
      cur_player <= 1'b0;
      move_count <= '0;
      move_err   <= 1'b0;
      move_done  <= 1'b0;
      pr_q       <= '0;
      pc_q       <= '0;
      cr_q       <= '0;
      cc_q       <= '0;
      dir_q      <= 2'd0;
      run_q      <= '0;
    end else begin
      move_err  <= reject | undo_bad;
      move_done <= 1'b0;
      if (accept) begin
        board[tidx +: 2] <= pcode;
        move_count       <= move_count + CNT_W'(1);
        run_q            <= RUN_W'(1);
        dir_q            <= 2'd0;
        pr_q             <= {1'b0, x_in};
        pc_q             <= {1'b0, y_in};
        cr_q             <= {1'b0, x_in};
        cc_q             <= {1'b0, y_in};
      end
`ifdef MNK_UNDO_EN
      if (undo_go) begin
        board[pidx +: 2] <= 2'b00;
        move_count       <= move_count - CNT_W'(1);
        winner           <= 2'b00;
        tie              <= 1'b0;
        cur_player       <= pop_code[1];
        move_done        <= 1'b1;
      end
`endif
      case (state_q)
        SCAN_POS, SCAN_NEG: begin
          if (step_hit) begin
            run_q <= run_q + RUN_W'(1);
            cr_q  <= nr;
            cc_q  <= nc;
            if (win_hit) begin
              winner    <= pcode;
              move_done <= 1'b1;
            end
          end else begin
            // Each half-scan restarts from the placed stone.
            cr_q <= pr_q;
            cc_q <= pc_q;
          end
        end
        NEXT_DIR: begin
          if (dir_q != 2'd3) begin
            dir_q <= dir_q + 2'd1;
            run_q <= RUN_W'(1);
          end else begin
            if (move_count == NN_C) tie <= 1'b1;
            else                    cur_player <= ~cur_player;
            move_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mnk_game_engine.sv
// Directed bench for mnk_game_engine: a 3x3/K=3 instance and a 5x5/K=4 instance.
// Undo checks are compiled in when MNK_UNDO_EN is defined.
module tb_mnk_game_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  a_x, a_y, b_x, b_y;
  logic        a_mm, a_undo, b_mm, b_undo;
  logic        a_ready, a_err, a_done, a_cur, a_tie;
  logic        b_ready, b_err, b_done, b_cur, b_tie;
  logic [1:0]  a_win, b_win;
  logic [3:0]  a_cnt;
  logic [4:0]  b_cnt;
  logic [17:0] a_board;
  logic [49:0] b_board;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_a, exp_b;
  bit err;

  mnk_game_engine #(.N(3), .K(3), .COORD_W(4)) dut_a (
    .clk(clk), .rst(rst), .x_in(a_x), .y_in(a_y), .make_move(a_mm), .undo(a_undo),
    .move_ready(a_ready), .move_err(a_err), .move_done(a_done), .cur_player(a_cur),
    .winner(a_win), .tie(a_tie), .move_count(a_cnt), .board(a_board)
  );

  mnk_game_engine #(.N(5), .K(4), .COORD_W(4)) dut_b (
    .clk(clk), .rst(rst), .x_in(b_x), .y_in(b_y), .make_move(b_mm), .undo(b_undo),
    .move_ready(b_ready), .move_err(b_err), .move_done(b_done), .cur_player(b_cur),
    .winner(b_win), .tie(b_tie), .move_count(b_cnt), .board(b_board)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] put(input logic [63:0] b, input int n, input int r,
                                      input int c, input logic [1:0] code);
    logic [63:0] t;
    t = b;
    t[2*(n*n-1-(r*n+c)) +: 2] = code;
    return t;
  endfunction

  // Presents one move at a negedge, then waits (bounded) for move_done or move_err.
  task automatic play(input bit sel, input int r, input int c, output bit e);
    int t;
    int bound;
    bound = sel ? 8*(4-1)+5 : 8*(3-1)+5;
    if (sel) begin b_x = 4'(r); b_y = 4'(c); b_mm = 1'b1; end
    else     begin a_x = 4'(r); a_y = 4'(c); a_mm = 1'b1; end
    @(negedge clk);
    a_mm = 1'b0;
    b_mm = 1'b0;
    t = 1;
    while (!(sel ? (b_done | b_err) : (a_done | a_err)) && t <= 200) begin
      @(negedge clk);
      t++;
    end
    e = sel ? b_err : a_err;
    if (t > 200) check("move_timeout", sel ? {b_done, b_err} : {a_done, a_err}, 1);
    else if (!e) check("latency_bound", t <= bound, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_x = '0; a_y = '0; a_mm = 1'b0; a_undo = 1'b0;
    b_x = '0; b_y = '0; b_mm = 1'b0; b_undo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_board",  a_board, 0);
    check("rst_winner", a_win, 0);
    check("rst_tie",    a_tie, 0);
    check("rst_cur",    a_cur, 0);
    check("rst_cnt",    a_cnt, 0);
    check("rst_ready",  a_ready, 1);
    check("rst_err",    a_err, 0);
    check("rst_done",   a_done, 0);
    check("rst_b_ready", b_ready, 1);

    // X wins along the top row
    exp_a = '0;
    play(0, 0, 0, err); check("w1_err", err, 0); exp_a = put(exp_a, 3, 0, 0, 2'b01);
    check("w1_cur", a_cur, 1);
    play(0, 1, 0, err); check("w2_err", err, 0); exp_a = put(exp_a, 3, 1, 0, 2'b10);
    play(0, 0, 1, err); check("w3_err", err, 0); exp_a = put(exp_a, 3, 0, 1, 2'b01);
    play(0, 1, 1, err); check("w4_err", err, 0); exp_a = put(exp_a, 3, 1, 1, 2'b10);
    check("w4_winner", a_win, 0);
    play(0, 0, 2, err); check("w5_err", err, 0); exp_a = put(exp_a, 3, 0, 2, 2'b01);
    check("win_winner", a_win, 2'b01);
    check("win_row0",   a_board[17:12], 6'b010101);
    check("win_board",  a_board, exp_a);
    check("win_ready",  a_ready, 0);
    check("win_tie",    a_tie, 0);
    check("win_cnt",    a_cnt, 5);
    check("win_cur",    a_cur, 0);
    play(0, 2, 2, err); check("over_reject", err, 1);
    check("over_board", a_board, exp_a);

`ifdef MNK_UNDO_EN
    a_undo = 1'b1;
    @(negedge clk);
    a_undo = 1'b0;
    check("undo_done",   a_done, 1);
    check("undo_winner", a_win, 0);
    check("undo_cell",   a_board[13:12], 0);
    check("undo_cur",    a_cur, 0);
    check("undo_cnt",    a_cnt, 4);
    check("undo_ready",  a_ready, 1);
`endif

    // Full-board draw
    do_reset();
    play(0, 0, 0, err); play(0, 0, 1, err); play(0, 0, 2, err);
    play(0, 1, 1, err); play(0, 1, 0, err); play(0, 1, 2, err);
    play(0, 2, 1, err); play(0, 2, 0, err);
    check("draw8_tie", a_tie, 0);
    play(0, 2, 2, err);
    check("draw_err",    err, 0);
    check("draw_tie",    a_tie, 1);
    check("draw_winner", a_win, 0);
    check("draw_cnt",    a_cnt, 9);
    check("draw_ready",  a_ready, 0);

    // Rejections: occupied cell and out-of-range coordinate
    do_reset();
    exp_a = '0;
    play(0, 0, 0, err); check("rej_first", err, 0); exp_a = put(exp_a, 3, 0, 0, 2'b01);
    play(0, 0, 0, err); check("rej_dup", err, 1);
    check("rej_dup_board", a_board, exp_a);
    check("rej_dup_cur",   a_cur, 1);
    play(0, 3, 1, err); check("rej_range", err, 1);
    @(negedge clk);
    check("rej_pulse_1cy", a_err, 0);
    check("rej_cnt",       a_cnt, 1);
    check("rej_board",     a_board, exp_a);

    // Reset one cycle after an accept
    do_reset();
    a_x = 4'd1; a_y = 4'd1; a_mm = 1'b1;
    @(negedge clk);
    a_mm = 1'b0;
    check("mid_board_vis", a_board[9:8], 2'b01);
    check("mid_busy",      a_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_board",  a_board, 0);
    check("mid_rst_cnt",    a_cnt, 0);
    check("mid_rst_ready",  a_ready, 1);
    check("mid_rst_winner", a_win, 0);

`ifdef MNK_UNDO_EN
    a_undo = 1'b1;
    @(negedge clk);
    a_undo = 1'b0;
    check("undo_empty_err", a_err, 1);
    check("undo_empty_cnt", a_cnt, 0);
`endif

    // 5x5 K=4: (0,4) is flat-adjacent to (1,0) but must not join row 1
    do_reset();
    play(1, 1, 0, err); play(1, 3, 3, err); play(1, 1, 1, err); play(1, 3, 4, err);
    play(1, 0, 4, err); play(1, 4, 4, err); play(1, 1, 2, err);
    check("wrap_err",    err, 0);
    check("wrap_winner", b_win, 0);
    check("wrap_cur",    b_cur, 1);
    check("wrap_cnt",    b_cnt, 7);
    check("wrap_ready",  b_ready, 1);

    // 5x5 K=4: anti-diagonal completed at the corner-edge cell (4,0)
    do_reset();
    exp_b = '0;
    play(1, 1, 3, err); exp_b = put(exp_b, 5, 1, 3, 2'b01);
    play(1, 0, 0, err); exp_b = put(exp_b, 5, 0, 0, 2'b10);
    play(1, 2, 2, err); exp_b = put(exp_b, 5, 2, 2, 2'b01);
    play(1, 0, 1, err); exp_b = put(exp_b, 5, 0, 1, 2'b10);
    play(1, 3, 1, err); exp_b = put(exp_b, 5, 3, 1, 2'b01);
    play(1, 0, 4, err); exp_b = put(exp_b, 5, 0, 4, 2'b10);
    check("anti6_winner", b_win, 0);
    play(1, 4, 0, err); exp_b = put(exp_b, 5, 4, 0, 2'b01);
    check("anti_err",    err, 0);
    check("anti_winner", b_win, 2'b01);
    check("anti_board",  b_board, exp_b);
    check("anti_ready",  b_ready, 0);
    check("anti_tie",    b_tie, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
